gate_truth_table_sequencer: RTL



---
 rtl/gate_seq_pkg.sv | 20 ++
 rtl/btn_debounce_pulse.sv | 43 ++++
 rtl/gate_truth_table_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate-demo sequencers: FSM state encodings and
// the reference function for the gate under test.
package gate_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_CHECK = 3'd2,
    ST_DWELL = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } seq_state_e;

  localparam logic [1:0] VEC_LAST = 2'd3;

  function automatic logic nand_expected(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioner: two-flop synchroniser, stable-high counter and a
// one-clock pulse on the first clock the button is seen as debounced-high.
module btn_debounce_pulse #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic srst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Counter saturates at CNT_MAX, so reaching it doubles as the edge history.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    if (sync_q[1]) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    pulse_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Walks the four {A,B} vectors through an external 2-input NAND, checks each
// response and reports pass/fail; auto-advance or single-step between vectors.
module gate_truth_table_sequencer
  import gate_seq_pkg::*;
#(
  parameter int STEP_TICKS    = 100_000_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int DB_CYCLES     = 1_000_000
) (
  input  logic       I_P_CLK,
  input  logic       I_P_RST,
  input  logic       I_P_START,
  input  logic       I_P_STEP,
  input  logic       I_P_MODE,
  input  logic       I_P_GATE_Y,
  output logic       O_P_GATE_A,
  output logic       O_P_GATE_B,
  output logic       O_P_LED_A,
  output logic       O_P_LED_B,
  output logic [1:0] O_P_VEC_IDX,
  output logic       O_P_LED_BUSY,
  output logic       O_P_LED_PASS,
  output logic       O_P_LED_FAIL
);

  localparam int DWELL_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(STEP_TICKS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                mode_q, mode_d;
  logic                mode_prev_q, mode_prev_d;
  logic                busy_q, busy_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                start_pulse, step_pulse;

  btn_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_start_db (
    .clk     (I_P_CLK),
    .srst    (I_P_RST),
    .btn_raw (I_P_START),
    .pulse   (start_pulse)
  );

  btn_debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk     (I_P_CLK),
    .srst    (I_P_RST),
    .btn_raw (I_P_STEP),
    .pulse   (step_pulse)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    dwell_d     = dwell_q;
    mode_d      = I_P_MODE;
    mode_prev_d = mode_q;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start_pulse) begin
          state_d  = ST_APPLY;
          idx_d    = '0;
          settle_d = '0;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_CHECK: begin
        if (I_P_GATE_Y != nand_expected(idx_q[1], idx_q[0])) begin
          state_d = ST_FAIL;
        end else if (idx_q == VEC_LAST) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_DWELL;
          dwell_d = '0;
        end
      end
      ST_DWELL: begin
        // A mode flip mid-dwell restarts timing from scratch in the new mode.
        if (mode_q != mode_prev_q) begin
          dwell_d = '0;
        end else if (mode_q ? step_pulse : (dwell_q == DWELL_LAST)) begin
          state_d  = ST_APPLY;
          idx_d    = idx_q + 2'd1;
          settle_d = '0;
        end else if (!mode_q) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_APPLY) || (state_d == ST_CHECK) || (state_d == ST_DWELL);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
      mode_prev_q <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  // Operands track the index register, so PASS/FAIL naturally freeze them.
  assign O_P_GATE_A   = idx_q[1];
  assign O_P_GATE_B   = idx_q[0];
  assign O_P_LED_A    = idx_q[1];
  assign O_P_LED_B    = idx_q[0];
  assign O_P_VEC_IDX  = idx_q;
  assign O_P_LED_BUSY = busy_q;
  assign O_P_LED_PASS = pass_q;
  assign O_P_LED_FAIL = fail_q;

endmodule
